// File: rtl/regfile_alu_engine.sv
// Register-file processing unit: one command at a time via valid/ready, sequenced
// IDLE -> READ -> EXEC (ALU ops only) -> WB, with add/sub flags and a signed-amount shifter.
module regfile_alu_engine #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int EXEC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              ovf,
  output logic              done
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXEC_LAT - 1);
  localparam logic [DATA_W-1:0] DW_C     = DATA_W'(DATA_W);
  localparam int MSB = DATA_W - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [2:0] OP_WRITE  = 3'b000;
  localparam logic [2:0] OP_READ1  = 3'b001;
  localparam logic [2:0] OP_READ2  = 3'b010;
  localparam logic [2:0] OP_RD1_WR = 3'b011;
  localparam logic [2:0] OP_RD2_WR = 3'b100;
  localparam logic [2:0] OP_ADD    = 3'b101;
  localparam logic [2:0] OP_SUB    = 3'b110;
  localparam logic [2:0] OP_SHIFT  = 3'b111;

  // Non-negative amount shifts left; negative shifts right arithmetically by its magnitude.
  function automatic logic [DATA_W-1:0] shift_f(input logic [DATA_W-1:0] val,
                                                 input logic [DATA_W-1:0] amt);
    logic [DATA_W-1:0] mag;
    mag = -amt;
    if (!amt[MSB]) begin
      if (amt >= DW_C) shift_f = {DATA_W{1'b0}};
      else             shift_f = val << amt;
    end else begin
      if (mag >= DW_C) shift_f = {DATA_W{val[MSB]}};
      else             shift_f = DATA_W'($signed(val) >>> mag);
    end
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d, opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, res_q, res_d;
  logic              carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [DATA_W:0]   sum_s, diff_s;
  logic [DATA_W-1:0] wb_rd1_s, wb_rd2_s, wb_res_s;
  logic              wb_carry_s, wb_ovf_s, wb_we_s;

  assign sum_s  = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff_s = {1'b0, opa_q} - {1'b0, opb_q};

  // Write-back values per opcode; ports the opcode does not read stay zero.
  always_comb begin
    wb_rd1_s   = {DATA_W{1'b0}};
    wb_rd2_s   = {DATA_W{1'b0}};
    wb_res_s   = {DATA_W{1'b0}};
    wb_carry_s = 1'b0;
    wb_ovf_s   = 1'b0;
    wb_we_s    = 1'b0;
    case (op_q)
      OP_WRITE: begin
        wb_res_s = imm_q;
        wb_we_s  = 1'b1;
      end
      OP_READ1: begin
        wb_rd1_s = opa_q;
      end
      OP_READ2: begin
        wb_rd1_s = opa_q;
        wb_rd2_s = opb_q;
      end
      OP_RD1_WR: begin
        wb_rd1_s = opa_q;
        wb_res_s = imm_q;
        wb_we_s  = 1'b1;
      end
      OP_RD2_WR: begin
        wb_rd1_s = opa_q;
        wb_rd2_s = opb_q;
        wb_res_s = imm_q;
        wb_we_s  = 1'b1;
      end
      OP_ADD: begin
        wb_rd1_s   = opa_q;
        wb_rd2_s   = opb_q;
        wb_res_s   = sum_s[DATA_W-1:0];
        wb_carry_s = sum_s[DATA_W];
        wb_ovf_s   = (opa_q[MSB] == opb_q[MSB]) && (sum_s[MSB] != opa_q[MSB]);
        wb_we_s    = 1'b1;
      end
      OP_SUB: begin
        wb_rd1_s   = opa_q;
        wb_rd2_s   = opb_q;
        wb_res_s   = diff_s[DATA_W-1:0];
        wb_carry_s = diff_s[DATA_W];
        wb_ovf_s   = (opa_q[MSB] != opb_q[MSB]) && (diff_s[MSB] != opa_q[MSB]);
        wb_we_s    = 1'b1;
      end
      OP_SHIFT: begin
        wb_rd1_s = opa_q;
        wb_res_s = shift_f(opa_q, imm_q);
        wb_we_s  = 1'b1;
      end
      default: begin
        wb_we_s = 1'b0;
      end
    endcase
  end

  // Sequencer next-state: command latch, operand fetch, EXEC countdown, output update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = opcode;
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd;
          imm_d   = imm;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        opa_d = regs_q[rs1_q];
        opb_d = regs_q[rs2_q];
        cnt_d = {CNT_W{1'b0}};
        if (op_q >= OP_ADD) state_d = ST_EXEC;
        else                state_d = ST_WB;
      end
      ST_EXEC: begin
        if (cnt_q == CNT_LAST) state_d = ST_WB;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WB: begin
        rd1_d   = wb_rd1_s;
        rd2_d   = wb_rd2_s;
        res_d   = wb_res_s;
        carry_d = wb_carry_s;
        ovf_d   = wb_ovf_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control, command and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'b000;
      rs1_q   <= {ADDR_W{1'b0}};
      rs2_q   <= {ADDR_W{1'b0}};
      rd_q    <= {ADDR_W{1'b0}};
      imm_q   <= {DATA_W{1'b0}};
      opa_q   <= {DATA_W{1'b0}};
      opb_q   <= {DATA_W{1'b0}};
      rd1_q   <= {DATA_W{1'b0}};
      rd2_q   <= {DATA_W{1'b0}};
      res_q   <= {DATA_W{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Register file; operands were captured in READ, so a same-address write stays read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {DATA_W{1'b0}};
    end else if ((state_q == ST_WB) && wb_we_s) begin
      regs_q[rd_q] <= wb_res_s;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rd1_data  = rd1_q;
  assign rd2_data  = rd2_q;
  assign result    = res_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_alu_engine.sv
// Randomised bench for regfile_alu_engine against an arithmetic reference model
// of the register file, including directed flag/shift corners and mid-command reset.
module tb_regfile_alu_engine;

  localparam int W   = 16;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int NR  = 2 ** AW;
  localparam longint MASK = (longint'(1) << W) - 1;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] rs1, rs2, rd;
  logic [W-1:0]  imm;
  logic [W-1:0]  rd1_data, rd2_data, result;
  logic          carry, ovf, done;

  regfile_alu_engine #(.DATA_W(W), .ADDR_W(AW), .EXEC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .result(result),
    .carry(carry), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] mregs [NR];
  logic [W-1:0] last_res, last_rd1;
  logic         last_c, last_o;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v);
    return (v > SMAX) ? v - (longint'(1) << W) : v;
  endfunction

  // Reference model: expected outputs from the current model register contents.
  task automatic model(input logic [2:0] op, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [W-1:0] im,
                       output logic [W-1:0] e_rd1, output logic [W-1:0] e_rd2,
                       output logic [W-1:0] e_res, output logic e_c, output logic e_o,
                       output logic e_we, output int e_lat);
    longint a, b, sa, sb, si, t;
    a  = longint'(mregs[r1]);
    b  = longint'(mregs[r2]);
    sa = sx(a);
    sb = sx(b);
    si = sx(longint'(im));
    e_rd1 = (op != 3'd0) ? W'(a) : '0;
    e_rd2 = (op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6) ? W'(b) : '0;
    e_we  = !(op == 3'd1 || op == 3'd2);
    e_lat = (op >= 3'd5) ? 2 + LAT : 2;
    e_c   = 1'b0;
    e_o   = 1'b0;
    e_res = '0;
    case (op)
      3'd0, 3'd3, 3'd4: e_res = im;
      3'd5: begin
        t     = a + b;
        e_res = W'(t & MASK);
        e_c   = (t > MASK);
        e_o   = (sa + sb > SMAX) || (sa + sb < SMIN);
      end
      3'd6: begin
        e_res = W'((a - b) & MASK);
        e_c   = (a < b);
        e_o   = (sa - sb > SMAX) || (sa - sb < SMIN);
      end
      3'd7: begin
        if (si >= 0) e_res = (si >= W) ? '0 : W'((a << si) & MASK);
        else if (-si >= W) e_res = (sa < 0) ? W'(MASK) : '0;
        else e_res = W'((sa >>> (-si)) & MASK);
      end
      default: e_res = '0;
    endcase
  endtask

  // Issue one command (entered just after an edge with the DUT idle) and check it.
  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] d, input logic [W-1:0] im, input bit hold);
    logic [W-1:0] e_rd1, e_rd2, e_res;
    logic e_c, e_o, e_we;
    int e_lat, n;
    model(op, r1, r2, im, e_rd1, e_rd2, e_res, e_c, e_o, e_we, e_lat);
    check_val("ready_before_accept", cmd_ready, 1'b1);
    cmd_valid = 1'b1; opcode = op; rs1 = r1; rs2 = r2; rd = d; imm = im;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    opcode = 3'($urandom); rs1 = AW'($urandom); rs2 = AW'($urandom);
    rd = AW'($urandom); imm = W'($urandom);
    n = 0;
    while (!done) begin
      check_val("ready_busy", cmd_ready, 1'b0);
      if (n >= 40) begin
        check_val("done_timeout", 32'(n), 32'(e_lat));
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check_val($sformatf("op%0d latency", op), 32'(n), 32'(e_lat));
    check_val($sformatf("op%0d rd1_data", op), rd1_data, e_rd1);
    check_val($sformatf("op%0d rd2_data", op), rd2_data, e_rd2);
    check_val($sformatf("op%0d result", op), result, e_res);
    check_val($sformatf("op%0d carry", op), carry, e_c);
    check_val($sformatf("op%0d ovf", op), ovf, e_o);
    check_val("ready_at_done", cmd_ready, 1'b1);
    if (e_we) mregs[d] = e_res;
    last_res = e_res; last_rd1 = e_rd1; last_c = e_c; last_o = e_o;
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] rim;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    rst = 1'b1; cmd_valid = 1'b0; opcode = 3'd0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset rd1_data", rd1_data, 16'h0000);
    check_val("reset rd2_data", rd2_data, 16'h0000);
    check_val("reset result", result, 16'h0000);
    check_val("reset flags", {carry, ovf, done}, 3'b000);
    rst = 1'b0;
    #1;
    check_val("reset ready", cmd_ready, 1'b1);

    run_cmd(3'd2, 5'd3, 5'd4, 5'd0, 16'h0000, 1'b0);
    run_cmd(3'd0, 5'd0, 5'd0, 5'd5, 16'h7FFF, 1'b0);
    run_cmd(3'd0, 5'd0, 5'd0, 5'd6, 16'h0001, 1'b0);
    run_cmd(3'd5, 5'd5, 5'd6, 5'd7, 16'h0000, 1'b0);
    check_val("add_corner", {result, carry, ovf}, {16'h8000, 1'b0, 1'b1});
    run_cmd(3'd1, 5'd7, 5'd0, 5'd0, 16'h0000, 1'b0);
    check_val("add_readback", rd1_data, 16'h8000);
    run_cmd(3'd6, 5'd6, 5'd5, 5'd8, 16'h0000, 1'b0);
    check_val("sub_corner", {result, carry, ovf}, {16'h8002, 1'b1, 1'b0});

    run_cmd(3'd0, 5'd0, 5'd0, 5'd10, 16'hF000, 1'b0);
    run_cmd(3'd0, 5'd0, 5'd0, 5'd11, 16'h0001, 1'b0);
    run_cmd(3'd7, 5'd10, 5'd0, 5'd12, 16'hFFFC, 1'b0);
    check_val("shift_neg4", result, 16'hFF00);
    run_cmd(3'd7, 5'd11, 5'd0, 5'd12, 16'd3, 1'b0);
    check_val("shift_pos3", result, 16'h0008);
    run_cmd(3'd7, 5'd11, 5'd0, 5'd12, 16'd20, 1'b0);
    check_val("shift_pos20", result, 16'h0000);
    run_cmd(3'd7, 5'd10, 5'd0, 5'd12, 16'hFFEC, 1'b0);
    check_val("shift_neg20", result, 16'hFFFF);

    run_cmd(3'd3, 5'd5, 5'd0, 5'd5, 16'h1234, 1'b0);
    check_val("rbw_rd1", {rd1_data, result}, {16'h7FFF, 16'h1234});
    run_cmd(3'd1, 5'd5, 5'd0, 5'd0, 16'h0000, 1'b0);
    check_val("rbw_readback", rd1_data, 16'h1234);

    // cmd_valid held high across back-to-back commands
    run_cmd(3'd4, 5'd5, 5'd6, 5'd13, 16'hBEEF, 1'b1);
    run_cmd(3'd5, 5'd13, 5'd5, 5'd14, 16'h0000, 1'b1);
    run_cmd(3'd2, 5'd13, 5'd14, 5'd0, 16'h0000, 1'b1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_val("hold_no_extra_done", done, 1'b0);
    check_val("hold_idle_ready", cmd_ready, 1'b1);

    for (int k = 0; k < 200; k++) begin
      rop = 3'($urandom);
      rim = (rop == 3'd7 && $urandom_range(0, 1) == 1) ? W'(int'($urandom_range(0, 48)) - 24)
                                                       : W'($urandom);
      run_cmd(rop, AW'($urandom), AW'($urandom), AW'($urandom), rim, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check_val("gap_done_low", done, 1'b0);
        check_val("gap_result_hold", result, last_res);
        check_val("gap_rd1_hold", rd1_data, last_rd1);
        check_val("gap_flags_hold", {carry, ovf}, {last_c, last_o});
      end
    end
    cmd_valid = 1'b0;

    // Abort an ADD to r9 in EXEC with reset
    run_cmd(3'd0, 5'd0, 5'd0, 5'd9, 16'hABCD, 1'b0);
    run_cmd(3'd0, 5'd0, 5'd0, 5'd5, 16'h0101, 1'b0);
    cmd_valid = 1'b1; opcode = 3'd5; rs1 = 5'd5; rs2 = 5'd9; rd = 5'd9; imm = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort outputs", {rd1_data, rd2_data, result}, 48'h0);
    check_val("abort flags", {carry, ovf, done}, 3'b000);
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check_val("abort_no_done", done, 1'b0);
    end
    check_val("abort_ready", cmd_ready, 1'b1);
    run_cmd(3'd1, 5'd9, 5'd0, 5'd0, 16'h0000, 1'b0);
    check_val("abort_r9_zero", rd1_data, 16'h0000);

    for (int i = 0; i < NR; i++) run_cmd(3'd2, AW'(i), AW'(NR - 1 - i), 5'd0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
